// File: rtl/aes_roundtrip.sv
// aes_roundtrip: iterative AES-128 round-trip checker.
// Encrypts plain_text under key (FIPS-197, one round per clock), then runs
// the inverse cipher on the result with the same key schedule.
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   start          begin operation (sampled only while idle)
//   plain_text     128-bit plaintext, captured on accepted start
//   key            128-bit cipher key, captured on accepted start
//   busy           high from the cycle after accepted start until done
//   done           one-cycle pulse, decrypted_text valid
//   cipher_text    encryption result (held until next operation writes it)
//   decrypted_text inverse-cipher result (held until next operation writes it)
// Byte 0 is bits [127:120]; state is column-major, byte n = row n%4, col n/4.
module aes_roundtrip (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] plain_text,
  input  logic [127:0] key,
  output logic         busy,
  output logic         done,
  output logic [127:0] cipher_text,
  output logic [127:0] decrypted_text
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ENC  = 2'd1,
    S_DEC  = 2'd2
  } fsm_e;

  // ---------------- GF(2^8) arithmetic ----------------
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 (254 = 2+4+...+128); maps 0 to 0.
  function automatic logic [7:0] ginv(input logic [7:0] x);
    logic [7:0] x2, x4, x8, x16, x32, x64, x128, r;
    x2   = gmul(x, x);
    x4   = gmul(x2, x2);
    x8   = gmul(x4, x4);
    x16  = gmul(x8, x8);
    x32  = gmul(x16, x16);
    x64  = gmul(x32, x32);
    x128 = gmul(x64, x64);
    r = gmul(x2, x4);
    r = gmul(r, x8);
    r = gmul(r, x16);
    r = gmul(r, x32);
    r = gmul(r, x64);
    r = gmul(r, x128);
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int unsigned n);
    logic [15:0] d;
    d = {b, b} << n;
    return d[15:8];
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] i;
    i = ginv(b);
    return i ^ rotl8(i, 1) ^ rotl8(i, 2) ^ rotl8(i, 3) ^ rotl8(i, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return ginv(rotl8(b, 1) ^ rotl8(b, 3) ^ rotl8(b, 6) ^ 8'h05);
  endfunction

  // ---------------- state transforms ----------------
  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int unsigned n = 0; n < 16; n++)
      o[127-8*n -: 8] = sbox(s[127-8*n -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int unsigned n = 0; n < 16; n++)
      o[127-8*n -: 8] = inv_sbox(s[127-8*n -: 8]);
    return o;
  endfunction

  // Row r rotates left by r columns.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int unsigned c = 0; c < 4; c++)
      for (int unsigned r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int unsigned c = 0; c < 4; c++)
      for (int unsigned r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+4-r)%4)+r) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
      o[119-32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
      o[111-32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
      o[103-32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
    end
    return o;
  endfunction

  // ---------------- key schedule ----------------
  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [127:0] key_expand(input logic [127:0] prev, input logic [3:0] r);
    logic [31:0] w0, w1, w2, w3, t, n0, n1, n2, n3;
    w0 = prev[127:96];
    w1 = prev[95:64];
    w2 = prev[63:32];
    w3 = prev[31:0];
    // SubWord(RotWord(w3)) ^ Rcon
    t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])}
         ^ {rcon(r), 24'h000000};
    n0 = w0 ^ t;
    n1 = w1 ^ n0;
    n2 = w2 ^ n1;
    n3 = w3 ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  // ---------------- registers ----------------
  fsm_e         fsm_q, fsm_d;
  logic [3:0]   rnd_q, rnd_d;
  logic [127:0] state_q, state_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic [127:0] cipher_q, cipher_d;
  logic [127:0] dec_q, dec_d;
  logic [127:0] rk_q [0:10];

  logic         rk_we;
  logic [3:0]   rk_widx;
  logic [127:0] rk_wdata;

  logic [127:0] rk_new;
  logic [127:0] enc_t;
  logic [127:0] dec_s;
  logic [127:0] dec_t;

  always_comb begin
    fsm_d    = fsm_q;
    rnd_d    = rnd_q;
    state_d  = state_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    cipher_d = cipher_q;
    dec_d    = dec_q;
    rk_we    = 1'b0;
    rk_widx  = '0;
    rk_wdata = '0;
    rk_new   = '0;
    enc_t    = '0;
    dec_s    = '0;
    dec_t    = '0;

    case (fsm_q)
      S_IDLE: begin
        if (start) begin
          state_d  = plain_text ^ key;
          rk_we    = 1'b1;
          rk_widx  = 4'd0;
          rk_wdata = key;
          fsm_d    = S_ENC;
          rnd_d    = 4'd1;
          busy_d   = 1'b1;
        end
      end

      S_ENC: begin
        rk_new   = key_expand(rk_q[rnd_q - 4'd1], rnd_q);
        rk_we    = 1'b1;
        rk_widx  = rnd_q;
        rk_wdata = rk_new;
        enc_t    = shift_rows(sub_bytes(state_q));
        if (rnd_q == 4'd10) begin
          state_d  = enc_t ^ rk_new;
          cipher_d = enc_t ^ rk_new;
          fsm_d    = S_DEC;
          rnd_d    = 4'd1;
        end else begin
          state_d  = mix_columns(enc_t) ^ rk_new;
          rnd_d    = rnd_q + 4'd1;
        end
      end

      S_DEC: begin
        // Initial AddRoundKey(rk[10]) is folded into the first inverse round.
        dec_s = (rnd_q == 4'd1) ? (state_q ^ rk_q[10]) : state_q;
        dec_t = inv_sub_bytes(inv_shift_rows(dec_s)) ^ rk_q[4'd10 - rnd_q];
        if (rnd_q == 4'd10) begin
          state_d = dec_t;
          dec_d   = dec_t;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          fsm_d   = S_IDLE;
          rnd_d   = 4'd0;
        end else begin
          state_d = inv_mix_columns(dec_t);
          rnd_d   = rnd_q + 4'd1;
        end
      end

      default: begin
        fsm_d  = S_IDLE;
        rnd_d  = 4'd0;
        busy_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q    <= S_IDLE;
      rnd_q    <= '0;
      state_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cipher_q <= '0;
      dec_q    <= '0;
      for (int unsigned i = 0; i < 11; i++) rk_q[i] <= '0;
    end else begin
      fsm_q    <= fsm_d;
      rnd_q    <= rnd_d;
      state_q  <= state_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      cipher_q <= cipher_d;
      dec_q    <= dec_d;
      if (rk_we) rk_q[rk_widx] <= rk_wdata;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign cipher_text    = cipher_q;
  assign decrypted_text = dec_q;

endmodule

// File: tb/tb_aes_roundtrip.sv
// Directed bench for aes_roundtrip: FIPS-197 vectors, key-schedule probe,
// start-while-busy, mid-operation reset and back-to-back operation.
module tb_aes_roundtrip;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [127:0] plain_text;
  logic [127:0] key;
  logic         busy;
  logic         done;
  logic [127:0] cipher_text;
  logic [127:0] decrypted_text;

  int errors = 0;
  int checks = 0;

  localparam logic [127:0] PT1  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] KEY1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT1  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] PT2  = 128'h0;
  localparam logic [127:0] KEY2 = 128'h0;
  localparam logic [127:0] CT2  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  aes_roundtrip dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .plain_text     (plain_text),
    .key            (key),
    .busy           (busy),
    .done           (done),
    .cipher_text    (cipher_text),
    .decrypted_text (decrypted_text)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Advance one edge at a time (sampling 1ns after the edge) until done, bounded.
  task automatic wait_done(output int cyc, output bit seen);
    seen = 1'b0;
    cyc  = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clk); #1;
      cyc++;
      if (done) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; plain_text = '0; key = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (cipher_text !== 128'h0) begin errors++; $display("FAIL reset_ct: got %h want 0", cipher_text); end
    checks++; if (decrypted_text !== 128'h0) begin errors++; $display("FAIL reset_dt: got %h want 0", decrypted_text); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_fips_vector();
    int cyc; bit seen;
    start = 1'b1; plain_text = PT1; key = KEY1;
    @(posedge clk); #1;
    start = 1'b0; plain_text = '0; key = '0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL v1_busy: got %b want 1", busy); end
    wait_done(cyc, seen);
    checks++; if (!seen || cyc !== 20) begin errors++; $display("FAIL v1_latency: got seen=%0d cycles=%0d want 20", seen, cyc); end
    checks++; if (cipher_text !== CT1) begin errors++; $display("FAIL v1_ct: got %h want %h", cipher_text, CT1); end
    checks++; if (decrypted_text !== PT1) begin errors++; $display("FAIL v1_dt: got %h want %h", decrypted_text, PT1); end
    checks++; if (dut.rk_q[1] !== RK1) begin errors++; $display("FAIL v1_rk1: got %h want %h", dut.rk_q[1], RK1); end
    checks++; if (dut.rk_q[10] !== RK10) begin errors++; $display("FAIL v1_rk10: got %h want %h", dut.rk_q[10], RK10); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL v1_after: got done=%b busy=%b want 0 0", done, busy); end
  endtask

  task automatic test_zero_vector();
    int cyc; bit seen;
    start = 1'b1; plain_text = PT2; key = KEY2;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(cyc, seen);
    checks++; if (!seen || cyc !== 20) begin errors++; $display("FAIL v2_latency: got seen=%0d cycles=%0d want 20", seen, cyc); end
    checks++; if (cipher_text !== CT2) begin errors++; $display("FAIL v2_ct: got %h want %h", cipher_text, CT2); end
    checks++; if (decrypted_text !== PT2) begin errors++; $display("FAIL v2_dt: got %h want %h", decrypted_text, PT2); end
    @(posedge clk); #1;
  endtask

  task automatic test_start_while_busy();
    int ndone; int first;
    ndone = 0; first = -1;
    start = 1'b1; plain_text = PT1; key = KEY1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 1; i <= 35; i++) begin
      @(posedge clk); #1;
      if (done) begin ndone++; if (first < 0) first = i; end
      if (i == 5) begin start = 1'b1; plain_text = PT2; key = KEY2; end
      if (i == 6) start = 1'b0;
    end
    checks++; if (ndone !== 1 || first !== 20) begin errors++; $display("FAIL busy_start_done: got pulses=%0d first=%0d want 1 at 20", ndone, first); end
    checks++; if (cipher_text !== CT1) begin errors++; $display("FAIL busy_start_ct: got %h want %h", cipher_text, CT1); end
    checks++; if (decrypted_text !== PT1) begin errors++; $display("FAIL busy_start_dt: got %h want %h", decrypted_text, PT1); end
  endtask

  task automatic test_reset_mid_op();
    int ndone; int cyc; bit seen;
    ndone = 0;
    start = 1'b1; plain_text = PT2; key = KEY2;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (12) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL midrst_done: got %b want 0", done); end
    checks++; if (cipher_text !== 128'h0) begin errors++; $display("FAIL midrst_ct: got %h want 0", cipher_text); end
    checks++; if (decrypted_text !== 128'h0) begin errors++; $display("FAIL midrst_dt: got %h want 0", decrypted_text); end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    checks++; if (ndone !== 0 || busy !== 1'b0) begin errors++; $display("FAIL midrst_quiet: got pulses=%0d busy=%b want 0 0", ndone, busy); end
    start = 1'b1; plain_text = PT1; key = KEY1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(cyc, seen);
    checks++; if (!seen || cyc !== 20) begin errors++; $display("FAIL midrst_restart_latency: got seen=%0d cycles=%0d want 20", seen, cyc); end
    checks++; if (cipher_text !== CT1) begin errors++; $display("FAIL midrst_restart_ct: got %h want %h", cipher_text, CT1); end
    checks++; if (decrypted_text !== PT1) begin errors++; $display("FAIL midrst_restart_dt: got %h want %h", decrypted_text, PT1); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int cyc; bit seen;
    start = 1'b1; plain_text = PT1; key = KEY1;
    @(posedge clk); #1;
    // start stays high; the next operation's inputs are presented right away
    plain_text = PT2; key = KEY2;
    wait_done(cyc, seen);
    checks++; if (!seen || cyc !== 20) begin errors++; $display("FAIL b2b_first_latency: got seen=%0d cycles=%0d want 20", seen, cyc); end
    checks++; if (cipher_text !== CT1) begin errors++; $display("FAIL b2b_first_ct: got %h want %h", cipher_text, CT1); end
    checks++; if (decrypted_text !== PT1) begin errors++; $display("FAIL b2b_first_dt: got %h want %h", decrypted_text, PT1); end
    // accept edge right after the done cycle, then 20 cycles of latency
    wait_done(cyc, seen);
    start = 1'b0;
    checks++; if (!seen || cyc !== 21) begin errors++; $display("FAIL b2b_second_gap: got seen=%0d cycles=%0d want 21", seen, cyc); end
    checks++; if (cipher_text !== CT2) begin errors++; $display("FAIL b2b_second_ct: got %h want %h", cipher_text, CT2); end
    checks++; if (decrypted_text !== PT2) begin errors++; $display("FAIL b2b_second_dt: got %h want %h", decrypted_text, PT2); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_fips_vector();
    test_zero_vector();
    test_start_while_busy();
    test_reset_mid_op();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
